cnn1d_exp_horner: RTL and testbench

- Parametrised fixed-point exp(x) evaluator for the cnn1d datapath, e.g. for softmax/activation stages.
- Computes the order-TERMS Taylor polynomial sum_{k=0..TERMS} x^k/k! by Horner's rule.
- Uses one shared signed multiplier iterated by an FSM, with valid/ready handshakes on input and output.
- Generalises the fixed package constants (fixed width/fraction, hard-coded factorials) to elaboration-time width, fraction and order, and adds saturation.

---
 rtl/cnn1d_exp_horner.sv | 150 +++++++++++++++
 tb/tb_cnn1d_exp_horner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cnn1d_exp_horner.sv
// rtl/cnn1d_exp_horner.sv - Horner-rule Taylor exp(x) on one shared multiplier, saturating.
// Optional sat_flag output when CNN1D_EXP_SAT_FLAG_EN is defined.
module cnn1d_exp_horner #(
  parameter int DATA_WIDTH = 16,
  parameter int FRACTION   = 12,
  parameter int TERMS      = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] y_out
`ifdef CNN1D_EXP_SAT_FLAG_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int CW = $clog2(TERMS + 1);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = (TERMS + 1) * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] PMAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (TERMS < 1 || TERMS > 10) begin : g_terms_check
    $error("cnn1d_exp_horner: TERMS must be in 1..10");
  end
  if (FRACTION > DATA_WIDTH - 2) begin : g_fraction_check
    $error("cnn1d_exp_horner: FRACTION must be <= DATA_WIDTH-2");
  end

  // c_k = floor(2^FRACTION / k!) packed LSB-first, k = 0..TERMS
  function automatic logic [RW-1:0] build_rom();
    logic [RW-1:0]   r;
    logic [63:0]     f;
    r = '0;
    f = 64'd1;
    for (int k = 0; k <= TERMS; k++) begin
      if (k > 0) f = f * 64'(k);
      r[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((64'd1 << FRACTION) / f);
    end
    return r;
  endfunction

  localparam logic [RW-1:0] COEF_ROM = build_rom();
  localparam logic signed [DATA_WIDTH-1:0] C_TOP = COEF_ROM[TERMS*DATA_WIDTH +: DATA_WIDTH];

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                         state;
  logic signed [DATA_WIDTH-1:0]   acc;
  logic signed [DATA_WIDTH-1:0]   x_reg;
  logic [CW-1:0]                  cnt;

  logic signed [DATA_WIDTH-1:0]   coef_sel;
  logic signed [PW-1:0]           prod;
  logic signed [PW-1:0]           prod_sh;
  logic signed [DATA_WIDTH-1:0]   mul_sat;
  logic                           mul_ovf;
  logic signed [DATA_WIDTH:0]     sum;
  logic signed [DATA_WIDTH-1:0]   add_sat;
  logic                           add_ovf;

  always_comb begin
    coef_sel = '0;
    for (int k = 0; k < TERMS; k++) begin
      if (cnt == CW'(k + 1)) coef_sel = COEF_ROM[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // multiply, floor-shift, clip; then add coefficient one bit wider and clip again
  always_comb begin
    prod    = acc * x_reg;
    prod_sh = prod >>> FRACTION;
    mul_ovf = 1'b0;
    mul_sat = prod_sh[DATA_WIDTH-1:0];
    if (prod_sh > PMAX) begin
      mul_sat = SMAX;
      mul_ovf = 1'b1;
    end else if (prod_sh < PMIN) begin
      mul_sat = SMIN;
      mul_ovf = 1'b1;
    end
    sum     = {mul_sat[DATA_WIDTH-1], mul_sat} + {coef_sel[DATA_WIDTH-1], coef_sel};
    add_ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
    add_sat = sum[DATA_WIDTH-1:0];
    if (add_ovf) add_sat = sum[DATA_WIDTH] ? SMIN : SMAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      acc       <= '0;
      cnt       <= '0;
      x_reg     <= '0;
`ifdef CNN1D_EXP_SAT_FLAG_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= x_in;
            acc      <= C_TOP;
            cnt      <= CW'(TERMS);
            in_ready <= 1'b0;
            state    <= CALC;
`ifdef CNN1D_EXP_SAT_FLAG_EN
            sat_flag <= 1'b0;
`endif
          end
        end
        CALC: begin
          acc <= add_sat;
          cnt <= cnt - 1'b1;
`ifdef CNN1D_EXP_SAT_FLAG_EN
          sat_flag <= sat_flag | mul_ovf | add_ovf;
`endif
          if (cnt == CW'(1)) begin
            y_out     <= add_sat;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn1d_exp_horner.sv
// tb/tb_cnn1d_exp_horner.sv - Directed vector bench for cnn1d_exp_horner (W=16, F=12, N=6).
module tb_cnn1d_exp_horner;

  localparam int TERMS = 6;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] y_out;
`ifdef CNN1D_EXP_SAT_FLAG_EN
  logic               sat_flag;
`endif

  int checks   = 0;
  int failures = 0;

  cnn1d_exp_horner #(.DATA_WIDTH(16), .FRACTION(12), .TERMS(TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
`ifdef CNN1D_EXP_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present x and wait for the accepting edge; returns at the negedge after it.
  task automatic issue(input logic signed [15:0] x);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready_timeout", longint'(in_ready), 1);
    in_valid = 1'b1;
    x_in     = x;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0] = '{x: 16'sd0,      y: 16'sd4096,  sat: 1'b0};
    vecs[1] = '{x: 16'sd4096,   y: 16'sd11131, sat: 1'b0};
    vecs[2] = '{x: -16'sd4096,  y: 16'sd1507,  sat: 1'b0};
    vecs[3] = '{x: 16'sd28672,  y: 16'sd32767, sat: 1'b1};
    vecs[4] = '{x: 16'sd2048,   y: 16'sd6753,  sat: 1'b0};
    vecs[5] = '{x: -16'sd2048,  y: 16'sd2484,  sat: 1'b0};
    vecs[6] = '{x: -16'sd32768, y: 16'sd32767, sat: 1'b1};
    vecs[7] = '{x: 16'sd1,      y: 16'sd4097,  sat: 1'b0};
    vecs[8] = '{x: -16'sd1,     y: 16'sd4095,  sat: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_y_out", longint'(y_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].x);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), longint'(lat), TERMS);
      check($sformatf("vec%0d_y", i), longint'(y_out), longint'(vecs[i].y));
`ifdef CNN1D_EXP_SAT_FLAG_EN
      check($sformatf("vec%0d_sat", i), longint'(sat_flag), longint'(vecs[i].sat));
`endif
      drain();
    end

    // backpressure: result held, new operand ignored until IDLE
    issue(16'sd4096);
    wait_result(lat);
    in_valid = 1'b1;
    x_in     = 16'sd0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_y", c), longint'(y_out), 11131);
      check($sformatf("hold%0d_out_valid", c), longint'(out_valid), 1);
      check($sformatf("hold%0d_in_ready", c), longint'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", longint'(out_valid), 0);
    check("release_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_operand_accepted", longint'(in_ready), 0);
    wait_result(lat);
    check("held_latency", longint'(lat), TERMS);
    check("held_y", longint'(y_out), 4096);
    drain();

    // asynchronous reset three cycles into CALC
    issue(16'sd4096);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", longint'(in_ready), 1);
    check("async_rst_out_valid", longint'(out_valid), 0);
    check("async_rst_y_out", longint'(y_out), 0);
`ifdef CNN1D_EXP_SAT_FLAG_EN
    check("async_rst_sat", longint'(sat_flag), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'sd2048);
    wait_result(lat);
    check("post_rst_latency", longint'(lat), TERMS);
    check("post_rst_y", longint'(y_out), 6753);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
